pe: RTL and testbench

Processing element of the column-parallel integer matrix multiplier. One instance per output column. It forwards the A/B operand streams to the next instance, captures its own column of B and accumulates one column of C = A×B into a small result memory. A row address reads that memory back. Instances are chained: each one's output_* ports drive the next one's inputs, and the last instance has next_PE_ack tied high.

---
 rtl/pe.sv | 120 ++++++++++++
 tb/tb_pe.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pe.sv
// pe: matrix-multiply processing element; forwards A/B lanes, captures its B column,
// accumulates one column of C into a result memory. Define PE_DOUBLE_BUFFER_EN for two result banks.
module pe #(
    parameter int log_size = 2,
    parameter int index    = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         a,
    input  logic [31:0]         b,
    input  logic                stb,
    input  logic                input_b_valid,
    input  logic                next_PE_ack,
    output logic                input_ack,
    input  logic [log_size-1:0] addr,
    input  logic                mem_select,
    output logic [31:0]         c,
    output logic [31:0]         output_a,
    output logic [31:0]         output_b,
    output logic                output_b_valid,
    output logic                output_stb
);
    localparam int n  = 1 << log_size;
    localparam int tw = 2 * log_size + 1;
    localparam logic [tw-1:0]       nv    = tw'(n);
    localparam logic [tw-1:0]       nsq   = tw'(n * n);
    localparam logic [tw-1:0]       last  = tw'(n * n + n - 1);
    localparam logic [log_size-1:0] col   = log_size'(index - 1);
    localparam logic [log_size-1:0] lastj = log_size'(n - 1);

    logic [tw-1:0]         t;
    logic [tw-1:0]         ta;
    logic [log_size-1:0]   j;
    logic [log_size-1:0]   r;
    logic [log_size:0]     ka;
    logic [31:0]           bcap;
    logic [31:0]           bwork;
    logic [31:0]           bnext;
    logic [31:0]           acc_old;
    logic [31:0]           sum;
    logic                  adv;
    logic                  in_b;
    logic                  cnt;
    logic                  fin;
`ifdef PE_DOUBLE_BUFFER_EN
    logic                  wbank;
    logic [31:0]           mem [2][n];
`else
    logic                  unused_sel;
    logic [31:0]           mem [n];
`endif

    // Beat decode: which lane is active and the MAC operands for this beat
    always_comb begin
        adv       = stb & next_PE_ack;
        input_ack = adv;
        in_b      = t < nsq;
        cnt       = adv & (~in_b | input_b_valid);
        fin       = cnt & (t == last);
        j         = t[log_size-1:0];
        ta        = t - nv;
        r         = ta[log_size-1:0];
        ka        = ta[tw-1:log_size];
        bnext     = (col == lastj) ? b : bcap;
`ifdef PE_DOUBLE_BUFFER_EN
        acc_old   = mem[wbank][r];
        c         = mem[mem_select][addr];
`else
        unused_sel = mem_select;
        acc_old   = mem[r];
        c         = mem[addr];
`endif
        sum       = ((ka == '0) ? 32'd0 : acc_old) + a * bwork;
    end

    // Forwarding registers, beat counter, B capture and frame completion
    always_ff @(posedge clk) begin
        if (rst) begin
            t              <= '0;
            bcap           <= '0;
            bwork          <= '0;
            output_a       <= '0;
            output_b       <= '0;
            output_b_valid <= 1'b0;
            output_stb     <= 1'b0;
        end else if (adv) begin
            output_a       <= a;
            output_b       <= b;
            output_b_valid <= input_b_valid;
            if (cnt) begin
                if (in_b && j == col) bcap <= b;
                if (in_b && j == lastj) bwork <= bnext;
                t <= fin ? '0 : t + 1'b1;
                if (fin) output_stb <= 1'b1;
            end
        end
    end

    // Result memory: MAC into the write bank on A-lane beats, bank flips at frame end
    always_ff @(posedge clk) begin
        if (rst) begin
`ifdef PE_DOUBLE_BUFFER_EN
            wbank <= 1'b0;
            for (int i = 0; i < n; i++) begin
                mem[0][i] <= '0;
                mem[1][i] <= '0;
            end
`else
            for (int i = 0; i < n; i++) mem[i] <= '0;
`endif
        end else if (cnt) begin
`ifdef PE_DOUBLE_BUFFER_EN
            if (t >= nv) mem[wbank][r] <= sum;
            if (fin) wbank <= ~wbank;
`else
            if (t >= nv) mem[r] <= sum;
`endif
        end
    end
endmodule

// File: tb/tb_pe.sv
// tb_pe: directed self-checking bench for two log_size=1 PEs (columns 0 and 1) fed in parallel.
module tb_pe;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic        stb = 1'b0, input_b_valid = 1'b0, next_PE_ack = 1'b1;
    logic        addr = 1'b0, mem_select = 1'b0;
    logic        ack0, ack1, obv0, obv1, ostb0, ostb1;
    logic [31:0] c0, c1, oa0, oa1, ob0, ob1;
    logic [31:0] am [4];
    logic [31:0] bm [4];
    logic [31:0] last_av;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pe #(.log_size(1), .index(1)) u0 (
        .clk(clk), .rst(rst), .a(a), .b(b), .stb(stb), .input_b_valid(input_b_valid),
        .next_PE_ack(next_PE_ack), .input_ack(ack0), .addr(addr), .mem_select(mem_select),
        .c(c0), .output_a(oa0), .output_b(ob0), .output_b_valid(obv0), .output_stb(ostb0));

    pe #(.log_size(1), .index(2)) u1 (
        .clk(clk), .rst(rst), .a(a), .b(b), .stb(stb), .input_b_valid(input_b_valid),
        .next_PE_ack(next_PE_ack), .input_ack(ack1), .addr(addr), .mem_select(mem_select),
        .c(c1), .output_a(oa1), .output_b(ob1), .output_b_valid(obv1), .output_stb(ostb1));

    task automatic drive(input logic [31:0] av, input logic [31:0] bv, input logic v, input logic s, input logic k);
        @(negedge clk);
        a = av;
        b = bv;
        input_b_valid = v;
        stb = s;
        next_PE_ack = k;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        stb = 1'b1;
        next_PE_ack = 1'b1;
        input_b_valid = 1'b1;
        a = 32'h55;
        b = 32'h66;
        @(negedge clk);
        rst = 1'b0;
        stb = 1'b0;
        input_b_valid = 1'b0;
    endtask

    task automatic frame(input int upto, input int stall_at, input int gap_at);
        logic [31:0] av, bv;
        int ta;
        for (int t = 0; t < upto; t++) begin
            ta = t - 2;
            av = (t < 2) ? 32'd0 : am[(ta & 1) * 2 + (ta >> 1)];
            bv = (t < 4) ? bm[t] : 32'd0;
            if (t == gap_at) begin
                for (int g = 0; g < 2; g++) begin
                    drive(av, 32'hDEAD, 1'b0, 1'b1, 1'b1);
                    if (g == 1) begin
                        checks++;
                        if (obv0 !== 1'b0) begin
                            errors++;
                            $display("FAIL gap_valid got %0b want 0", obv0);
                        end
                    end
                end
            end
            if (t == stall_at) begin
                for (int s = 0; s < 3; s++) begin
                    drive(av, bv, 1'b1, 1'b1, 1'b0);
                    #1;
                    checks++;
                    if (ack0 !== 1'b0 || ack1 !== 1'b0) begin
                        errors++;
                        $display("FAIL stall_ack got %0b/%0b want 0/0", ack0, ack1);
                    end
                    checks++;
                    if (oa0 !== last_av) begin
                        errors++;
                        $display("FAIL stall_output_a got %0h want %0h", oa0, last_av);
                    end
                end
            end
            drive(av, bv, t < 4, 1'b1, 1'b1);
            last_av = av;
        end
        drive(32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic load_basic();
        am[0] = 1; am[1] = 2; am[2] = 3; am[3] = 4;
        bm[0] = 5; bm[1] = 6; bm[2] = 7; bm[3] = 8;
    endtask

    task automatic check_basic(input string tag);
        mem_select = 1'b0;
        addr = 1'b0;
        #1;
        checks++;
        if (c0 !== 32'd19 || c1 !== 32'd22) begin
            errors++;
            $display("FAIL %s row0 got %0d/%0d want 19/22", tag, c0, c1);
        end
        addr = 1'b1;
        #1;
        checks++;
        if (c0 !== 32'd43 || c1 !== 32'd50) begin
            errors++;
            $display("FAIL %s row1 got %0d/%0d want 43/50", tag, c0, c1);
        end
        checks++;
        if (ostb0 !== 1'b1 || ostb1 !== 1'b1) begin
            errors++;
            $display("FAIL %s output_stb got %0b/%0b want 1/1", tag, ostb0, ostb1);
        end
    endtask

    task automatic test_reset();
        do_reset();
        addr = 1'b0;
        #1;
        checks++;
        if (c0 !== 32'd0 || c1 !== 32'd0) begin
            errors++;
            $display("FAIL reset_c got %0d/%0d want 0/0", c0, c1);
        end
        checks++;
        if (ostb0 !== 1'b0 || obv0 !== 1'b0 || oa0 !== 32'd0 || ob0 !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs got stb=%0b bv=%0b a=%0h b=%0h want all 0", ostb0, obv0, oa0, ob0);
        end
    endtask

    task automatic test_forwarding();
        do_reset();
        drive(32'h11, 32'h22, 1'b1, 1'b1, 1'b1);
        #1;
        checks++;
        if (ack0 !== 1'b1) begin
            errors++;
            $display("FAIL fwd_ack got %0b want 1", ack0);
        end
        drive(32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (oa0 !== 32'h11 || ob0 !== 32'h22 || obv0 !== 1'b1) begin
            errors++;
            $display("FAIL fwd got a=%0h b=%0h v=%0b want 11/22/1", oa0, ob0, obv0);
        end
    endtask

    task automatic test_basic();
        do_reset();
        load_basic();
        frame(5, -1, -1);
        checks++;
        if (ostb0 !== 1'b0) begin
            errors++;
            $display("FAIL early_stb got %0b want 0", ostb0);
        end
        do_reset();
        frame(6, -1, -1);
        check_basic("basic");
    endtask

    task automatic test_backpressure();
        do_reset();
        load_basic();
        frame(6, 3, -1);
        check_basic("backpressure");
    endtask

    task automatic test_gaps();
        do_reset();
        load_basic();
        frame(6, -1, 2);
        check_basic("gaps");
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            am[i] = 32'hFFFFFFFF;
            bm[i] = 32'hFFFFFFFF;
        end
        frame(6, -1, -1);
        for (int r = 0; r < 2; r++) begin
            addr = r[0];
            #1;
            checks++;
            if (c0 !== 32'd2 || c1 !== 32'd2) begin
                errors++;
                $display("FAIL wrap row%0d got %0h/%0h want 2/2", r, c0, c1);
            end
        end
    endtask

    task automatic test_reset_mid();
        frame(3, -1, -1);
        do_reset();
        addr = 1'b0;
        #1;
        checks++;
        if (c0 !== 32'd0 || c1 !== 32'd0 || ostb0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got c=%0h/%0h stb=%0b want 0/0/0", c0, c1, ostb0);
        end
        load_basic();
        frame(6, -1, -1);
        check_basic("after_reset");
        for (int i = 0; i < 4; i++) begin
            am[i] = 32'hFFFFFFFF;
            bm[i] = 32'hFFFFFFFF;
        end
        frame(6, -1, -1);
        addr = 1'b1;
        mem_select = 1'b1;
        #1;
        checks++;
        if (c0 !== 32'd2) begin
            errors++;
            $display("FAIL frame2_sel1 got %0h want 2", c0);
        end
        mem_select = 1'b0;
        #1;
        checks++;
`ifdef PE_DOUBLE_BUFFER_EN
        if (c0 !== 32'd43) begin
            errors++;
            $display("FAIL bank0_kept got %0d want 43", c0);
        end
`else
        if (c0 !== 32'd2) begin
            errors++;
            $display("FAIL single_bank got %0h want 2", c0);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_basic();
        test_backpressure();
        test_gaps();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
